// File: rtl/pack_buffer_arbiter_pkg.sv
// Shared constants and types for the packing-buffer arbiter and its datapath core.
package pack_buffer_arbiter_pkg;

  localparam int unsigned BufWidth = 320;
  localparam int unsigned WordW    = 64;

  localparam logic ClientId0 = 1'b0;
  localparam logic ClientId1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pack_buffer_core.sv
// Bit-level packing buffer: insert at fill, 64-bit right shift on pop, flush round-up,
// plus the push/pop legality checks.
module pack_buffer_core
  import pack_buffer_arbiter_pkg::*;
#(
  parameter int unsigned BufW  = BufWidth,
  parameter int unsigned C0W   = 40,
  parameter int unsigned C1W   = 16,
  parameter int unsigned FillW = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             own_i,
  input  logic             owner_i,
  input  logic             clear_i,
  input  logic             c0_push_i,
  input  logic [C0W-1:0]   c0_data_i,
  input  logic             c1_push_i,
  input  logic [C1W-1:0]   c1_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WordW-1:0] buf_word_o,
  output logic             word_valid_o,
  output logic [FillW-1:0] fill_o,
  output logic             push_err_o,
  output logic             pop_err_o
);

  // One extra bit so fill + width never wraps before the overflow compare.
  localparam int unsigned     CntW     = FillW + 1;
  localparam logic [CntW-1:0] WordCnt  = CntW'(WordW);
  localparam logic [CntW-1:0] BufCnt   = CntW'(BufW);
  localparam logic [CntW-1:0] C0Cnt    = CntW'(C0W);
  localparam logic [CntW-1:0] C1Cnt    = CntW'(C1W);
  localparam logic [CntW-1:0] RoundAdd = CntW'(WordW - 1);
  localparam logic [CntW-1:0] RoundMsk = ~CntW'(WordW - 1);

  logic [BufW-1:0]  buf_q, buf_d;
  logic [FillW-1:0] fill_q, fill_d;

  logic [CntW-1:0]  fill_ext, base, need, after, rounded, push_cnt;
  logic [BufW-1:0]  push_vec, shifted;
  logic             pop_ok, own_push, foreign_push, push_ok;

  always_comb begin
    fill_ext     = {1'b0, fill_q};
    pop_ok       = pop_i & own_i & (fill_ext >= WordCnt);
    own_push     = own_i & (owner_i ? c1_push_i : c0_push_i);
    foreign_push = own_i ? (owner_i ? c0_push_i : c1_push_i) : (c0_push_i | c1_push_i);
    push_cnt     = owner_i ? C1Cnt : C0Cnt;
    push_vec     = owner_i ? BufW'(c1_data_i) : BufW'(c0_data_i);

    // Pop is applied first, so a same-cycle push lands 64 bits lower.
    base    = pop_ok ? (fill_ext - WordCnt) : fill_ext;
    need    = base + push_cnt;
    push_ok = own_push & (need <= BufCnt);
    after   = push_ok ? need : base;
    rounded = (after + RoundAdd) & RoundMsk;

    shifted = pop_ok ? (buf_q >> WordW) : buf_q;
    // Bits above fill are always zero, so OR-ing the shifted data is an insert.
    buf_d   = push_ok ? (shifted | (push_vec << base)) : shifted;
    fill_d  = FillW'(flush_i ? rounded : after);

    if (clear_i) begin
      buf_d  = '0;
      fill_d = '0;
    end

    push_err_o = (own_push & ~push_ok) | foreign_push;
    pop_err_o  = pop_i & ~pop_ok;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

  assign buf_word_o   = buf_q[WordW-1:0];
  assign word_valid_o = ({1'b0, fill_q} >= WordCnt);
  assign fill_o       = fill_q;

endmodule

// File: rtl/pack_buffer_arbiter.sv
// Round-robin ownership arbiter for the shared packing buffer, with registered grants
// and a sticky protocol-error flag.
module pack_buffer_arbiter
  import pack_buffer_arbiter_pkg::*;
#(
  parameter int unsigned BufW  = BufWidth,
  parameter int unsigned C0W   = 40,
  parameter int unsigned C1W   = 16,
  parameter int unsigned FillW = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             c0_req_i,
  input  logic             c0_rel_i,
  output logic             c0_gnt_o,
  input  logic             c0_push_i,
  input  logic [C0W-1:0]   c0_data_i,
  input  logic             c1_req_i,
  input  logic             c1_rel_i,
  output logic             c1_gnt_o,
  input  logic             c1_push_i,
  input  logic [C1W-1:0]   c1_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WordW-1:0] buf_word_o,
  output logic             word_valid_o,
  output logic [FillW-1:0] fill_o,
  output logic             err_o
);

  arb_state_e       state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic             c0_gnt_q, c0_gnt_d, c1_gnt_q, c1_gnt_d;
  logic             err_q, err_d;
  logic             rel_ok, rel_err, own, owner;
  logic             push_err, pop_err;
  logic [FillW-1:0] fill;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      rr_last_q <= ClientId1;
      c0_gnt_q  <= 1'b0;
      c1_gnt_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      c0_gnt_q  <= c0_gnt_d;
      c1_gnt_q  <= c1_gnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    rel_ok    = 1'b0;
    rel_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        rel_err = c0_rel_i | c1_rel_i;
        if (c0_req_i && c1_req_i) begin
          state_d = (rr_last_q == ClientId1) ? StOwn0 : StOwn1;
        end else if (c0_req_i) begin
          state_d = StOwn0;
        end else if (c1_req_i) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        rel_err = c1_rel_i;
        if (c0_rel_i) begin
          state_d   = StIdle;
          rr_last_d = ClientId0;
          rel_ok    = 1'b1;
        end
      end
      StOwn1: begin
        rel_err = c0_rel_i;
        if (c1_rel_i) begin
          state_d   = StIdle;
          rr_last_d = ClientId1;
          rel_ok    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Grants lag the state by one cycle so they are clean register outputs.
  always_comb begin
    own      = (state_q != StIdle);
    owner    = (state_q == StOwn1) ? ClientId1 : ClientId0;
    c0_gnt_d = (state_q == StOwn0);
    c1_gnt_d = (state_q == StOwn1);
  end

  always_comb begin
    err_d = err_q | rel_err | (rel_ok & (|fill)) | push_err | pop_err;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  pack_buffer_core #(
    .BufW  (BufW),
    .C0W   (C0W),
    .C1W   (C1W),
    .FillW (FillW)
  ) u_core (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .own_i        (own),
    .owner_i      (owner),
    .clear_i      (rel_ok),
    .c0_push_i    (c0_push_i),
    .c0_data_i    (c0_data_i),
    .c1_push_i    (c1_push_i),
    .c1_data_i    (c1_data_i),
    .pop_i        (pop_i),
    .flush_i      (flush_i),
    .buf_word_o   (buf_word_o),
    .word_valid_o (word_valid_o),
    .fill_o       (fill),
    .push_err_o   (push_err),
    .pop_err_o    (pop_err)
  );

  assign c0_gnt_o = c0_gnt_q;
  assign c1_gnt_o = c1_gnt_q;
  assign fill_o   = fill;
  assign err_o    = err_q;

endmodule

// File: tb/tb_pack_buffer_arbiter.sv
// Bench for pack_buffer_arbiter: bit-queue reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_pack_buffer_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_req, c0_rel, c0_push, c1_req, c1_rel, c1_push, pop, flush;
  logic [39:0] c0_data;
  logic [15:0] c1_data;
  logic        c0_gnt, c1_gnt, word_valid, err;
  logic [63:0] buf_word;
  logic [8:0]  fill;

  always #5 clk = ~clk;

  pack_buffer_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .c0_req_i     (c0_req),
    .c0_rel_i     (c0_rel),
    .c0_gnt_o     (c0_gnt),
    .c0_push_i    (c0_push),
    .c0_data_i    (c0_data),
    .c1_req_i     (c1_req),
    .c1_rel_i     (c1_rel),
    .c1_gnt_o     (c1_gnt),
    .c1_push_i    (c1_push),
    .c1_data_i    (c1_data),
    .pop_i        (pop),
    .flush_i      (flush),
    .buf_word_o   (buf_word),
    .word_valid_o (word_valid),
    .fill_o       (fill),
    .err_o        (err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: the buffer is a queue of bits, index 0 = buffer bit 0.
  bit mq[$];
  int m_owner = -1;
  bit m_rr = 1'b1, m_g0 = 1'b0, m_g1 = 1'b0, m_err = 1'b0;

  function automatic logic [63:0] m_word();
    logic [63:0] w = '0;
    for (int i = 0; i < 64; i++) if (i < mq.size()) w[i] = mq[i];
    return w;
  endfunction

  always @(posedge clk) begin : model
    int          sz0, nxt, w;
    bit          rel_ok, pop_ok, opush;
    logic [63:0] d;
    if (rst) begin
      mq.delete();
      m_owner = -1; m_rr = 1'b1; m_g0 = 1'b0; m_g1 = 1'b0; m_err = 1'b0;
    end else begin
      sz0  = mq.size();
      m_g0 = (m_owner == 0);
      m_g1 = (m_owner == 1);
      nxt  = m_owner;
      rel_ok = 1'b0;
      if (m_owner < 0) begin
        if (c0_rel || c1_rel) m_err = 1'b1;
        if (c0_req && c1_req) nxt = m_rr ? 0 : 1;
        else if (c0_req) nxt = 0;
        else if (c1_req) nxt = 1;
      end else begin
        if (m_owner == 0 ? c1_rel : c0_rel) m_err = 1'b1;
        if (m_owner == 0 ? c0_rel : c1_rel) rel_ok = 1'b1;
      end
      pop_ok = pop && (m_owner >= 0) && (sz0 >= 64);
      if (pop && !pop_ok) m_err = 1'b1;
      if (pop_ok) for (int i = 0; i < 64; i++) void'(mq.pop_front());
      if (m_owner < 0) begin
        if (c0_push || c1_push) m_err = 1'b1;
      end else begin
        if (m_owner == 0 ? c1_push : c0_push) m_err = 1'b1;
        opush = (m_owner == 0) ? c0_push : c1_push;
        w     = (m_owner == 0) ? 40 : 16;
        d     = (m_owner == 0) ? {24'd0, c0_data} : {48'd0, c1_data};
        if (opush) begin
          if (mq.size() + w <= 320) for (int i = 0; i < w; i++) mq.push_back(d[i]);
          else m_err = 1'b1;
        end
      end
      if (flush) while (mq.size() % 64 != 0) mq.push_back(1'b0);
      if (rel_ok) begin
        if (sz0 != 0) m_err = 1'b1;
        mq.delete();
        m_rr = (m_owner == 1);
        nxt  = -1;
      end
      m_owner = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (c0_gnt !== m_g0 || c1_gnt !== m_g1 || buf_word !== m_word() ||
          word_valid !== (mq.size() >= 64) || fill !== 9'(mq.size()) || err !== m_err) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t dut: gnt=%b%b word=%h wv=%b fill=%0d err=%b model: gnt=%b%b word=%h wv=%b fill=%0d err=%b",
                 $time, c1_gnt, c0_gnt, buf_word, word_valid, fill, err,
                 m_g1, m_g0, m_word(), (mq.size() >= 64), mq.size(), m_err);
      end
    end
  end

  task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input bit p0, input logic [39:0] d0, input bit p1, input logic [15:0] d1,
                      input bit pp, input bit fl, input bit r0, input bit r1);
    c0_push = p0; c0_data = d0; c1_push = p1; c1_data = d1;
    pop = pp; flush = fl; c0_rel = r0; c1_rel = r1;
    cyc();
    c0_push = 1'b0; c1_push = 1'b0; pop = 1'b0; flush = 1'b0; c0_rel = 1'b0; c1_rel = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; c0_req = 1'b0; c1_req = 1'b0; c0_rel = 1'b0; c1_rel = 1'b0;
    c0_push = 1'b0; c1_push = 1'b0; pop = 1'b0; flush = 1'b0; c0_data = '0; c1_data = '0;

    // Basic grant latency and two pushes.
    c0_req = 1'b1;
    do_reset();
    lit("rst_fill", fill, 0);
    lit("rst_err", err, 0);
    lit("rst_wv", word_valid, 0);
    lit("rst_gnt0", c0_gnt, 0);
    cyc();
    lit("gnt0_lag", c0_gnt, 0);
    cyc();
    lit("gnt0_on", c0_gnt, 1);
    step(1, 40'hAAAAAAAAAA, 0, 0, 0, 0, 0, 0);
    step(1, 40'h5555555555, 0, 0, 0, 0, 0, 0);
    lit("two_push_fill", fill, 80);
    lit("two_push_wv", word_valid, 1);
    lit("two_push_word", buf_word, 64'h555555AAAAAAAAAA);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    lit("pop_fill", fill, 16);
    lit("pop_word", buf_word, 64'h0000000000005555);

    // Reset mid-fill.
    do_reset();
    lit("midrst_fill", fill, 0);
    lit("midrst_word", buf_word, 0);
    lit("midrst_gnt0", c0_gnt, 0);

    // Fill to capacity, overflow, drain.
    cyc(2);
    for (int k = 1; k <= 8; k++) step(1, 40'(k), 0, 0, 0, 0, 0, 0);
    lit("full_fill", fill, 320);
    lit("full_word0", buf_word, 64'h0000020000000001);
    step(1, 40'd9, 0, 0, 0, 0, 0, 0);
    lit("ovf_err", err, 1);
    lit("ovf_fill", fill, 320);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1, 0, 0, 0);
    lit("drain_fill", fill, 0);

    // Round robin, release, client 1 traffic, pop+push, flush.
    c1_req = 1'b1;
    do_reset();
    cyc(2);
    lit("rr_gnt0", c0_gnt, 1);
    lit("rr_gnt1", c1_gnt, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    lit("regrant_gap", c1_gnt, 0);
    cyc();
    lit("regrant_gnt1", c1_gnt, 1);
    lit("regrant_gnt0", c0_gnt, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 16'h1234, 0, 0, 0, 0);
    lit("c1_word", buf_word, 64'h1234123412341234);
    step(0, 0, 1, 16'hBEEF, 1, 0, 0, 0);
    lit("poppush_fill", fill, 16);
    lit("poppush_word", buf_word, 64'h000000000000BEEF);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 16'h00FF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    lit("flush_fill", fill, 64);
    lit("flush_word", buf_word, 64'h00000000000000FF);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    lit("flush2_fill", fill, 64);
    lit("clean_err", err, 0);

    // Non-owner push.
    c1_req = 1'b0;
    do_reset();
    cyc(2);
    step(0, 0, 1, 16'h7777, 0, 0, 0, 0);
    lit("foreign_err", err, 1);
    lit("foreign_fill", fill, 0);

    // Release with data still buffered.
    do_reset();
    cyc(2);
    for (int k = 0; k < 7; k++) step(1, 40'(k + 3), 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, 0, 0, 0);
    lit("rel24_fill", fill, 24);
    lit("rel24_err0", err, 0);
    c0_req = 1'b0;
    step(0, 0, 0, 0, 0, 0, 1, 0);
    lit("rel24_err", err, 1);
    lit("rel24_clr", fill, 0);
    lit("rel24_word", buf_word, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r0, r1, p0, p1;
      if ($urandom_range(99) == 0) begin
        do_reset();
        continue;
      end
      if ($urandom_range(7) == 0) c0_req = ~c0_req;
      if ($urandom_range(7) == 0) c1_req = ~c1_req;
      r0 = (m_owner == 0 && $urandom_range(15) == 0) || $urandom_range(299) == 0;
      r1 = (m_owner == 1 && $urandom_range(15) == 0) || $urandom_range(299) == 0;
      if (r0 || r1) begin
        step(0, 0, 0, 0, 0, 0, r0, r1);
      end else begin
        p0 = (m_owner == 0) ? ($urandom_range(1) == 0) : ($urandom_range(49) == 0);
        p1 = (m_owner == 1) ? ($urandom_range(1) == 0) : ($urandom_range(49) == 0);
        step(p0, {8'($urandom), 32'($urandom)}, p1, 16'($urandom),
             $urandom_range(3) == 0, $urandom_range(11) == 0, 0, 0);
      end
    end

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
